// File: rtl/fetch_queue_if.sv
// Fetch-queue bundle: redirect request, ROM read port and decode-side byte stream.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     redirect;
    logic [15:0]              redirect_pc;
    logic [15:0]              rom_addr;
    logic                     rom_oe_n;
    logic [7:0]               rom_data;
    logic                     q_valid;
    logic [7:0]               q_data;
    logic [15:0]              q_pc;
    logic                     q_ready;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        input  redirect, redirect_pc, rom_data, q_ready,
        output rom_addr, rom_oe_n, q_valid, q_data, q_pc, level
    );

    modport slave (
        output redirect, redirect_pc, rom_data, q_ready,
        input  rom_addr, rom_oe_n, q_valid, q_data, q_pc, level
    );
endinterface

// File: rtl/fetch_queue.sv
// Sequential-PC ROM prefetcher feeding a DEPTH-entry {pc,byte} FIFO; one byte per ROM_WAIT cycles.
// Fetch parks in IDLE when the FIFO fills and resumes on a pop; redirect flushes and restarts.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ROM_WAIT = 1,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
    localparam logic [WW-1:0] WLAST = WW'(ROM_WAIT - 1);
    localparam logic [LW-1:0] FULL  = LW'(DEPTH);

    typedef enum logic {IDLE, READ} state_t;

    state_t        state_q, state_d;
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   rom_addr_q, rom_addr_d;
    logic          rom_oe_n_q, rom_oe_n_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [LW-1:0] level_q, level_d, level_pop;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [15:0]   mem_pc_q  [DEPTH];
    logic [7:0]    mem_dat_q [DEPTH];
    logic          pop, push, sample;

    always_comb begin
        pop        = (level_q != '0) && bus.q_ready && !bus.redirect;
        sample     = (state_q == READ) && (wcnt_q == WLAST);
        push       = sample && ((level_q != FULL) || pop) && !bus.redirect;
        level_pop  = level_q - LW'(pop);
        level_d    = level_pop + LW'(push);
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rom_addr_d = rom_addr_q;
        rom_oe_n_d = rom_oe_n_q;
        wcnt_d     = wcnt_q;
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        wr_ptr_d   = wr_ptr_q + AW'(push);

        case (state_q)
            IDLE: begin
                rom_oe_n_d = 1'b1;
                if (level_pop != FULL) begin
                    state_d    = READ;
                    rom_addr_d = fetch_pc_q;
                    rom_oe_n_d = 1'b0;
                    wcnt_d     = '0;
                end
            end
            READ: begin
                if (push) begin
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    if (level_d == FULL) begin
                        state_d    = IDLE;
                        rom_oe_n_d = 1'b1;
                    end else begin
                        rom_addr_d = fetch_pc_q + 16'd1;
                        wcnt_d     = '0;
                    end
                end else if (!sample) begin
                    wcnt_d = wcnt_q + WW'(1);
                end
                // sample with a full FIFO and no pop: hold wcnt at WLAST and retry next cycle
            end
            default: state_d = IDLE;
        endcase

        if (bus.redirect) begin
            state_d    = READ;
            fetch_pc_d = bus.redirect_pc;
            rom_addr_d = bus.redirect_pc;
            rom_oe_n_d = 1'b0;
            wcnt_d     = '0;
            level_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            rom_addr_q <= RESET_PC;
            rom_oe_n_q <= 1'b1;
            wcnt_q     <= '0;
            level_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rom_addr_q <= rom_addr_d;
            rom_oe_n_q <= rom_oe_n_d;
            wcnt_q     <= wcnt_d;
            level_q    <= level_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_pc_q[wr_ptr_q]  <= fetch_pc_q;
            mem_dat_q[wr_ptr_q] <= bus.rom_data;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.rom_oe_n = rom_oe_n_q;
    assign bus.q_valid  = (level_q != '0);
    assign bus.q_data   = mem_dat_q[rd_ptr_q];
    assign bus.q_pc     = mem_pc_q[rd_ptr_q];
    assign bus.level    = level_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench: ROM_WAIT=1 instance for streaming/stall/redirect/reset, ROM_WAIT=3 instance for wait-state pacing.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(4)) bus1 ();
    fetch_queue_if #(.DEPTH(4)) bus3 ();

    fetch_queue #(.DEPTH(4), .ROM_WAIT(1), .RESET_PC(16'h0000)) u_fq1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );
    fetch_queue #(.DEPTH(4), .ROM_WAIT(3), .RESET_PC(16'h0000)) u_fq3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        if (a < 16'h0010)      return 8'hA0 + a[7:0];
        else if (a == 16'hFFFE) return 8'hEE;
        else if (a == 16'hFFFF) return 8'hEF;
        else                    return 8'h5A;
    endfunction

    assign bus1.rom_data = rom_fn(bus1.rom_addr);
    assign bus3.rom_data = rom_fn(bus3.rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus1.redirect = 1'b0; bus1.redirect_pc = 16'h0000; bus1.q_ready = 1'b0;
        bus3.redirect = 1'b0; bus3.redirect_pc = 16'h0000; bus3.q_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(bus1.q_valid), 32'h0);
        chk("rst_level", 32'(bus1.level), 32'h0);
        chk("rst_oe_n",  32'(bus1.rom_oe_n), 32'h1);
        chk("rst_addr",  32'(bus1.rom_addr), 32'h0000);

        // 1: streaming with q_ready held high
        bus1.q_ready = 1'b1;
        reset = 1'b0;
        tick();
        chk("t1_valid_e0", 32'(bus1.q_valid), 32'h0);
        chk("t1_oe_e0",    32'(bus1.rom_oe_n), 32'h0);
        tick();
        chk("t1_valid_e1", 32'(bus1.q_valid), 32'h1);
        chk("t1_pc0",      32'(bus1.q_pc), 32'h0000);
        chk("t1_dat0",     32'(bus1.q_data), 32'hA0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("t1_pc",  32'(bus1.q_pc), 32'(i));
            chk("t1_dat", 32'(bus1.q_data), 32'hA0 + 32'(i));
            chk("t1_oe",  32'(bus1.rom_oe_n), 32'h0);
        end
        chk("t1_level", 32'(bus1.level), 32'h1);

        // 2: fill while stalled, then single pop
        bus1.q_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("t2_level_full", 32'(bus1.level), 32'h4);
        chk("t2_oe_idle",    32'(bus1.rom_oe_n), 32'h1);
        chk("t2_head",       32'(bus1.q_pc), 32'h0000);
        bus1.q_ready = 1'b1;
        tick();
        bus1.q_ready = 1'b0;
        chk("t2_level_pop", 32'(bus1.level), 32'h3);
        chk("t2_head1",     32'(bus1.q_pc), 32'h0001);
        chk("t2_addr4",     32'(bus1.rom_addr), 32'h0004);
        chk("t2_oe_read",   32'(bus1.rom_oe_n), 32'h0);
        tick();
        chk("t2_level_refill", 32'(bus1.level), 32'h4);
        chk("t2_oe_idle2",     32'(bus1.rom_oe_n), 32'h1);
        bus1.q_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("t2_pc",  32'(bus1.q_pc), 32'(i));
            chk("t2_dat", 32'(bus1.q_data), 32'hA0 + 32'(i));
        end

        // 3: redirect with level=3 and a read in flight; concurrent pop ignored
        bus1.q_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        chk("t3_level3", 32'(bus1.level), 32'h3);
        chk("t3_inflight", 32'(bus1.rom_oe_n), 32'h0);
        bus1.redirect = 1'b1; bus1.redirect_pc = 16'h0008; bus1.q_ready = 1'b1;
        tick();
        bus1.redirect = 1'b0; bus1.q_ready = 1'b0;
        chk("t3_valid0", 32'(bus1.q_valid), 32'h0);
        chk("t3_level0", 32'(bus1.level), 32'h0);
        chk("t3_addr",   32'(bus1.rom_addr), 32'h0008);
        chk("t3_oe",     32'(bus1.rom_oe_n), 32'h0);
        tick();
        chk("t3_valid1", 32'(bus1.q_valid), 32'h1);
        chk("t3_pc",     32'(bus1.q_pc), 32'h0008);
        chk("t3_dat",    32'(bus1.q_data), 32'hA8);
        tick();
        chk("t3_level2", 32'(bus1.level), 32'h2);
        chk("t3_pc_hold", 32'(bus1.q_pc), 32'h0008);

        // 4: redirect near the top of the address space, wrap to 0000
        bus1.redirect = 1'b1; bus1.redirect_pc = 16'hFFFE; bus1.q_ready = 1'b1;
        tick();
        bus1.redirect = 1'b0;
        chk("t4_level0", 32'(bus1.level), 32'h0);
        tick();
        chk("t4_pc_fffe",  32'(bus1.q_pc), 32'hFFFE);
        chk("t4_dat_fffe", 32'(bus1.q_data), 32'hEE);
        tick();
        chk("t4_pc_ffff",  32'(bus1.q_pc), 32'hFFFF);
        chk("t4_dat_ffff", 32'(bus1.q_data), 32'hEF);
        tick();
        chk("t4_pc_0000",  32'(bus1.q_pc), 32'h0000);
        chk("t4_dat_0000", 32'(bus1.q_data), 32'hA0);

        // 5: reset while a refill read is outstanding on a nearly full FIFO
        bus1.q_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        chk("t5_full", 32'(bus1.level), 32'h4);
        bus1.q_ready = 1'b1;
        tick();
        bus1.q_ready = 1'b0;
        chk("t5_read", 32'(bus1.rom_oe_n), 32'h0);
        reset = 1'b1;
        tick();
        chk("t5_oe",    32'(bus1.rom_oe_n), 32'h1);
        chk("t5_level", 32'(bus1.level), 32'h0);
        chk("t5_valid", 32'(bus1.q_valid), 32'h0);
        chk("t5_addr",  32'(bus1.rom_addr), 32'h0000);

        // 6: ROM_WAIT=3 pacing with q_ready high
        bus3.q_ready = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_valid_lat", 32'(bus3.q_valid), 32'h0);
            chk("t6_oe_lat",    32'(bus3.rom_oe_n), 32'h0);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t6_oe", 32'(bus3.rom_oe_n), 32'h0);
            if (i % 3 == 0) begin
                chk("t6_valid", 32'(bus3.q_valid), 32'h1);
                chk("t6_dat",   32'(bus3.q_data), 32'hA0 + 32'(i / 3));
                chk("t6_pc",    32'(bus3.q_pc), 32'(i / 3));
            end else begin
                chk("t6_gap", 32'(bus3.q_valid), 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
